seven_segment_scan: RTL and testbench

- Multi-digit, time-multiplexed seven-segment driver for the floor and status displays. Successor to the single-digit combinational decoder.
- Accepts a binary value on a load strobe and converts it to BCD sequentially (shift-add-3).
- Applies leading-zero blanking and overflow indication.
- Scans N_DIGITS common-enable digits from one shared segment bus.

---
 rtl/seven_segment_pkg.sv | 72 +++++++
 rtl/bcd_converter.sv | 89 ++++++++
 rtl/seven_segment_scan.sv | 152 +++++++++++++++
 tb/tb_seven_segment_scan.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scan driver: segment patterns,
// the 4-bit digit code type, converter state encoding and sizing helpers.
package seven_segment_pkg;

  // Segment patterns, seg[0]=a (top) ... seg[6]=g (middle), active high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  // Digit code: 0-9 are decimal values, two spare codes for blank and dash
  typedef logic [3:0] digit_code_t;
  localparam digit_code_t CODE_DASH  = 4'hE;
  localparam digit_code_t CODE_BLANK = 4'hF;

  // Shift-add-3 converter states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Map a digit code onto its segment pattern; unused codes show blank
  function automatic logic [6:0] seg_of(input digit_code_t code);
    logic [6:0] pat;
    case (code)
      4'd0:       pat = SEG_0;
      4'd1:       pat = SEG_1;
      4'd2:       pat = SEG_2;
      4'd3:       pat = SEG_3;
      4'd4:       pat = SEG_4;
      4'd5:       pat = SEG_5;
      4'd6:       pat = SEG_6;
      4'd7:       pat = SEG_7;
      4'd8:       pat = SEG_8;
      4'd9:       pat = SEG_9;
      CODE_DASH:  pat = SEG_DASH;
      default:    pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Number of decimal digits needed for the largest w-bit unsigned value
  function automatic int dec_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

  // 10 raised to n, used for the overflow threshold
  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD engine (shift-add-3). One start pulse captures
// bin; SHIFT runs VALUE_W cycles, then COMMIT holds the result with done=1
// for exactly one cycle. busy covers SHIFT and COMMIT.
module bcd_converter
  import seven_segment_pkg::*;
#(
  parameter int VALUE_W    = 7,
  parameter int OUT_DIGITS = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*OUT_DIGITS-1:0] bcd
);

  // Internal digit count must cover every representable input, even when
  // fewer digits are shown; the extra digits still take part in the shifts.
  localparam int NEED_DIGITS = dec_digits(VALUE_W);
  localparam int DIGITS      = (OUT_DIGITS > NEED_DIGITS) ? OUT_DIGITS : NEED_DIGITS;
  localparam int BCD_W       = 4 * DIGITS;
  localparam int SR_W        = BCD_W + VALUE_W;
  localparam int CNT_W       = $clog2(VALUE_W + 1);

  // Combined shift register: BCD digits on top, binary bits below
  logic [SR_W-1:0]  r_sr;
  logic [SR_W-1:0]  w_adj;
  logic [CNT_W-1:0] r_cnt;
  conv_state_t      r_state;
  logic             r_busy;
  logic             r_done;

  // Add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    w_adj = r_sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_sr[VALUE_W + 4*d +: 4] >= 4'd5)
        w_adj[VALUE_W + 4*d +: 4] = r_sr[VALUE_W + 4*d +: 4] + 4'd3;
    end
  end

  // Conversion FSM with registered busy/done
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sr    <= {{BCD_W{1'b0}}, bin};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sr <= w_adj << 1;
          if (r_cnt == CNT_W'(VALUE_W - 1)) begin
            r_done  <= 1'b1;
            r_state <= ST_COMMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_sr[VALUE_W +: 4*OUT_DIGITS];

endmodule

// File: rtl/seven_segment_scan.sv
// Multi-digit time-multiplexed seven-segment driver. A load strobe starts a
// sequential BCD conversion; the result is blanked/overflow-checked and
// committed to a display register, which is scanned onto a shared segment
// bus one digit at a time.
// Optional blinking is enabled by defining SEVEN_SEGMENT_SCAN_BLINK_EN.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int N_DIGITS  = 2,
  parameter int VALUE_W   = 7,
  parameter int SCAN_DIV  = 1000
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  , parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [VALUE_W-1:0]  value,
  input  logic                load,
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  input  logic                blink,
`endif
  output logic                busy,
  output logic                overflow,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an
);

  localparam int          IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int          SC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned LIMIT  = pow10(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic                  w_busy;
  logic                  w_done;
  logic                  w_start;
  logic                  w_value_ovf;
  logic [4*N_DIGITS-1:0] w_bcd;

  logic [SC_W-1:0]       r_scan;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_next;
  logic                  w_scan_tc;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_overflow;
  logic                  r_ovf_cap;

  digit_code_t           r_disp     [N_DIGITS];
  digit_code_t           w_new      [N_DIGITS];
  digit_code_t           w_disp_next[N_DIGITS];
  logic                  w_lead;
  logic [3:0]            w_nib;

  // A load is only accepted while no conversion is running
  assign w_start     = load & ~w_busy;
  assign w_value_ovf = (32'(value) >= LIMIT);

  bcd_converter #(
    .VALUE_W    (VALUE_W),
    .OUT_DIGITS (N_DIGITS)
  ) u_conv (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (w_start),
    .bin     (value),
    .busy    (w_busy),
    .done    (w_done),
    .bcd     (w_bcd)
  );

  // Build committed digit codes: dashes on overflow, else blank leading zeros
  always_comb begin
    w_lead = 1'b1;
    w_nib  = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) w_new[i] = CODE_BLANK;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_nib = w_bcd[4*i +: 4];
      if (r_ovf_cap) begin
        w_new[i] = CODE_DASH;
      end else if ((i != 0) && w_lead && (w_nib == 4'd0)) begin
        w_new[i] = CODE_BLANK;
      end else begin
        w_new[i] = w_nib;
        w_lead   = 1'b0;
      end
    end
  end

  // Display contents after this edge; COMMIT replaces them
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++)
      w_disp_next[i] = w_done ? w_new[i] : r_disp[i];
  end

  // Scan position after this edge
  always_comb begin
    w_scan_tc  = (r_scan == SC_W'(SCAN_DIV - 1));
    w_idx_next = r_idx;
    if (w_scan_tc)
      w_idx_next = (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
  end

  // Scan counter, registered an/seg, display register and overflow flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_scan     <= '0;
      r_idx      <= '0;
      r_an       <= AN_ONE;
      r_seg      <= SEG_BLANK;
      r_overflow <= 1'b0;
      r_ovf_cap  <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) r_disp[i] <= CODE_BLANK;
    end else begin
      r_scan <= w_scan_tc ? '0 : r_scan + 1'b1;
      r_idx  <= w_idx_next;
      r_an   <= AN_ONE << w_idx_next;
      r_seg  <= seg_of(w_disp_next[w_idx_next]);
      for (int i = 0; i < N_DIGITS; i++) r_disp[i] <= w_disp_next[i];
      if (w_start) r_ovf_cap  <= w_value_ovf;
      if (w_done)  r_overflow <= r_ovf_cap;
    end
  end

`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_off;

  // Blink phase: toggles every BLINK_DIV cycles while blink is held high
  always_ff @(posedge clock) begin
    if (!reset_n || !blink) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == BL_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign seg = r_seg & {7{~r_blink_off}};
`else
  assign seg = r_seg;
`endif

  assign an       = r_an;
  assign busy     = w_busy;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench for seven_segment_scan (N_DIGITS=2, VALUE_W=7,
// SCAN_DIV=3). A decimal-arithmetic reference model predicts an, seg,
// busy and overflow after every clock edge.
module tb_seven_segment_scan;

  localparam int N_DIGITS = 2;
  localparam int VALUE_W  = 7;
  localparam int SCAN_DIV = 3;
  localparam int LATENCY  = VALUE_W + 1;

  logic                clock;
  logic                reset_n;
  logic [VALUE_W-1:0]  value;
  logic                load;
  logic                busy;
  logic                overflow;
  logic [6:0]          seg;
  logic [N_DIGITS-1:0] an;

  int n_vec;
  int n_err;

  // reference model state
  logic [6:0] seg_table [10];
  logic [6:0] exp_disp  [N_DIGITS];
  int         m_cnt;
  int         m_idx;
  int         m_pend;
  int         m_pend_val;
  logic       m_ovf;

  seven_segment_scan #(
    .N_DIGITS (N_DIGITS),
    .VALUE_W  (VALUE_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
    .blink    (1'b0),
`endif
    .busy     (busy),
    .overflow (overflow),
    .seg      (seg),
    .an       (an)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // commit a value into the model display using decimal arithmetic
  task automatic model_apply(input int v);
    int lim;
    lim = 1;
    for (int i = 0; i < N_DIGITS; i++) lim = lim * 10;
    if (v >= lim) begin
      m_ovf = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) exp_disp[i] = 7'b1000000;
    end else begin
      int p;
      m_ovf = 1'b0;
      p = 1;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (i > 0 && v < p) exp_disp[i] = 7'b0000000;
        else                exp_disp[i] = seg_table[(v / p) % 10];
        p = p * 10;
      end
    end
  endtask

  // one clock: advance the model with the inputs seen at the edge, then check
  task automatic tick();
    @(posedge clock);
    if (!reset_n) begin
      m_cnt  = 0;
      m_idx  = 0;
      m_pend = 0;
      m_ovf  = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) exp_disp[i] = 7'b0000000;
    end else begin
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % N_DIGITS;
      end else begin
        m_cnt++;
      end
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) model_apply(m_pend_val);
      end else if (load) begin
        m_pend     = LATENCY;
        m_pend_val = int'(value);
      end
    end
    #1;
    check("an",       32'(an),       32'(1 << m_idx));
    check("seg",      32'(seg),      32'(exp_disp[m_idx]));
    check("busy",     32'(busy),     32'(m_pend > 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input int v);
    value = VALUE_W'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    seg_table[0] = 7'b0111111; seg_table[1] = 7'b0000110;
    seg_table[2] = 7'b1011011; seg_table[3] = 7'b1001111;
    seg_table[4] = 7'b1100110; seg_table[5] = 7'b1101101;
    seg_table[6] = 7'b1111101; seg_table[7] = 7'b0000111;
    seg_table[8] = 7'b1111111; seg_table[9] = 7'b1101111;
    n_vec = 0; n_err = 0;
    m_cnt = 0; m_idx = 0; m_pend = 0; m_pend_val = 0; m_ovf = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) exp_disp[i] = 7'b0000000;

    reset_n = 1'b0;
    load    = 1'b0;
    value   = '0;
    ticks(2);
    // load during reset must be ignored
    value = 7'd33; load = 1'b1;
    tick();
    load = 1'b0;
    reset_n = 1'b1;
    ticks(4);

    // value 0 shows "0" with digit 1 blank
    do_load(0);
    ticks(12);
    // 47: busy for exactly 8 cycles, then "47"
    do_load(47);
    ticks(12);
    // 100 overflows two digits: dashes
    do_load(100);
    ticks(12);
    // 5 clears overflow, digit 1 blank
    do_load(5);
    ticks(12);
    // second load while busy is dropped
    do_load(23);
    ticks(1);
    do_load(88);
    ticks(12);
    // 127 is the largest input, overflows
    do_load(127);
    ticks(12);
    do_load(99);
    ticks(12);
    // reset mid-conversion aborts and blanks
    do_load(64);
    ticks(3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ticks(6);
    do_load(10);
    ticks(12);

    // randomized loads at random times, including while busy
    for (int i = 0; i < 400; i++) begin
      value = VALUE_W'($urandom_range(0, 127));
      load  = ($urandom_range(0, 5) == 0);
      tick();
    end
    load = 1'b0;
    ticks(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
